// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  // Smallest divisor that still yields a distinct low and high phase.
  localparam int unsigned MIN_DIV = 2;

  // Reduced configuration used by the block-level bench.
  localparam int unsigned TB_CNT_W   = 8;
  localparam int unsigned TB_DEF_DIV = 4;

  // Raise illegal divisors to MIN_DIV; callers size the result back to CNT_W.
  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: registered near-50% clk_out,
// single-cycle tick enable, shadowed divisor applied on period boundaries.
// Optional macro CLK_DIV_PHASE_EN adds the phase and half outputs.
//
// The active divisor is held as last = N-1 so that the default N = 2**CNT_W
// (the legacy counter-MSB divider) fits in CNT_W bits.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned     CNT_W   = 21,
  parameter longint unsigned DEF_DIV = 64'd1 << 21
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_PHASE_EN
  ,
  output logic [CNT_W-1:0] phase,
  output logic             half
`endif
);

  localparam longint unsigned DIV_MAX = 64'd1 << CNT_W;
  localparam longint unsigned DEF_ACT =
      (DEF_DIV < 64'(MIN_DIV)) ? 64'(MIN_DIV) :
      (DEF_DIV > DIV_MAX)      ? DIV_MAX      : DEF_DIV;
  localparam logic [CNT_W-1:0] DEF_LAST = CNT_W'(DEF_ACT - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             clk_q, clk_d;

  logic [CNT_W-1:0] load_last_c;
  logic [CNT_W-1:0] lo_c;
  logic             tick_c;
  logic             apply_c;

  // Next-state: count/wrap, shadow capture, boundary apply, clk_out from next count.
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    load_last_c = CNT_W'(clamp_div(32'(div_val)) - 32'd1);
    tick_c      = en && (cnt_q == last_q);
    // A load coincident with the wrap joins that wrap; while frozen only an
    // already-pending divisor is applied.
    apply_c     = tick_c ? (pend_q || div_load) : (!en && pend_q);

    if (div_load) begin
      shadow_d = load_last_c;
      pend_d   = 1'b1;
    end

    if (tick_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (apply_c) begin
      last_d = shadow_d;
      pend_d = 1'b0;
      cnt_d  = '0;
    end

    ack_d = apply_c;
    // Low phase length ceil(N/2) = floor((N-1)/2) + 1.
    lo_c  = (last_d >> 1) + CNT_W'(1);
    clk_d = (cnt_d >= lo_c);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= '0;
      last_q   <= DEF_LAST;
      shadow_q <= DEF_LAST;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      clk_q    <= clk_d;
    end
  end

  assign tick    = tick_c;
  assign div_ack = ack_q;
  assign clk_out = clk_q;

`ifdef CLK_DIV_PHASE_EN
  logic half_q;

  // Registered rising-edge strobe of clk_out.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      half_q <= 1'b0;
    end else begin
      half_q <= clk_d & ~clk_q;
    end
  end

  assign phase = cnt_q;
  assign half  = half_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (CNT_W=8, DEF_DIV=4) against a
// period-position reference model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int unsigned W = TB_CNT_W;

  logic         clk_in   = 1'b0;
  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val  = '0;
  logic         div_ack;
  logic         clk_out;
  logic         tick;
`ifdef CLK_DIV_PHASE_EN
  logic [W-1:0] phase;
  logic         half;
`endif

  clk_div_prog #(.CNT_W(W), .DEF_DIV(64'(TB_DEF_DIV))) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .div_ack (div_ack),
    .clk_out (clk_out),
    .tick    (tick)
`ifdef CLK_DIV_PHASE_EN
    ,
    .phase   (phase),
    .half    (half)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: active period length, position inside it, pending request.
  int m_n;
  int m_pos;
  int m_shadow;
  bit m_pend;
  bit m_ack;
  bit exp_clk, exp_tick, exp_ack;
  int exp_pos;

  function automatic int legal(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_n = TB_DEF_DIV; m_pos = 0; m_pend = 0; m_ack = 0; m_shadow = 0;
  endtask

  // Apply one cycle of inputs, record expected outputs for it, advance the model.
  task automatic drive(input bit r, input bit e, input bit l, input int v);
    bit old_pend;
    bit next_ack;
    @(negedge clk_in);
    rst = r; en = e; div_load = l; div_val = W'(v);
    #1;
    exp_pos  = m_pos;
    exp_tick = e && (m_pos == m_n - 1);
    exp_clk  = (m_pos >= (m_n + 1) / 2);
    exp_ack  = m_ack;
    if (r) begin
      model_reset();
    end else begin
      old_pend = m_pend;
      next_ack = 0;
      if (l) begin m_shadow = legal(v); m_pend = 1; end
      if (e) begin
        if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_pend) begin m_n = m_shadow; m_pend = 0; next_ack = 1; end
        end else begin
          m_pos++;
        end
      end else if (old_pend) begin
        m_n = m_shadow; m_pend = 0; m_pos = 0; next_ack = 1;
      end
      m_ack = next_ack;
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 9);
    drive(0, 0, 0, 0);
    if ({clk_out, tick, div_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset: clk/tick/ack=%b%b%b exp 000", clk_out, tick, div_ack);
    end
    checks++;
  endtask

  task automatic test_default_div();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0);
      if ({clk_out, tick, div_ack} !== {((i % 4) >= 2), ((i % 4) == 3), 1'b0}) begin
        errors++;
        $display("FAIL default_div cyc %0d: clk/tick/ack=%b%b%b exp %b%b0",
                 i, clk_out, tick, div_ack, ((i % 4) >= 2), ((i % 4) == 3));
      end
      checks++;
    end
  endtask

  task automatic test_load_mid();
    int ack_at;
    ack_at = -1;
    for (int k = 0; k < 16 && m_pos != 1; k++) drive(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, (i == 0), 5);
      if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
        errors++;
        $display("FAIL load_mid cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                 i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
      end
      checks++;
      if (div_ack === 1'b1 && ack_at < 0) ack_at = i;
    end
    if (ack_at !== 3) begin
      errors++;
      $display("FAIL load_mid_ack_latency: got %0d exp 3", ack_at);
    end
    checks++;
  endtask

  task automatic test_clamp();
    bit prev;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        drive(0, 1, (i == 0), pass);
        if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
          errors++;
          $display("FAIL clamp%0d cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                   pass, i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
        end
        checks++;
        if (i > 10 && clk_out === prev) begin
          errors++;
          $display("FAIL clamp%0d_toggle cyc %0d: clk_out=%b exp %b", pass, i, clk_out, ~prev);
        end
        if (i > 10) checks++;
        prev = clk_out;
      end
    end
  endtask

  task automatic test_multi_load();
    int acks, first_tick, spacing;
    // Widen the period so two loads fit before the boundary.
    for (int i = 0; i < 12; i++) drive(0, 1, (i == 0), 6);
    for (int k = 0; k < 16 && m_pos != 1; k++) drive(0, 1, 0, 0);
    acks = 0; first_tick = -1; spacing = 0;
    for (int i = 0; i < 36; i++) begin
      drive(0, 1, (i < 2), (i == 0) ? 7 : 9);
      if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
        errors++;
        $display("FAIL multi_load cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                 i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
      end
      checks++;
      if (div_ack === 1'b1) acks++;
      if (tick === 1'b1 && acks > 0) begin
        if (first_tick < 0) first_tick = i;
        else if (spacing == 0) spacing = i - first_tick;
      end
    end
    if (acks !== 1 || spacing !== 9) begin
      errors++;
      $display("FAIL multi_load_last_wins: acks=%0d period=%0d exp acks=1 period=9", acks, spacing);
    end
    checks++;
    // Load exactly on the tick cycle: applied at that wrap.
    for (int k = 0; k < 16 && m_pos != m_n - 1; k++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 3);
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL coincident_tick: tick=%b exp 1", tick);
    end
    checks++;
    drive(0, 1, 0, 0);
    if ({div_ack, clk_out} !== 2'b10) begin
      errors++;
      $display("FAIL coincident_ack: ack/clk=%b%b exp 10", div_ack, clk_out);
    end
    checks++;
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0);
      if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
        errors++;
        $display("FAIL coincident_run cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                 i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
      end
      checks++;
    end
  endtask

  task automatic test_freeze();
    bit held;
    for (int k = 0; k < 16 && m_pos != 2; k++) drive(0, 1, 0, 0);
    held = exp_clk;
    drive(0, 1, 0, 0);
    held = clk_out;
    for (int k = 0; k < 16 && m_pos != 2; k++) drive(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if ({clk_out, tick, div_ack} !== {exp_clk, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL freeze cyc %0d: clk/tick/ack=%b%b%b exp %b00",
                 i, clk_out, tick, div_ack, exp_clk);
      end
      checks++;
    end
    drive(0, 0, 1, 6);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    if ({clk_out, tick, div_ack} !== 3'b001) begin
      errors++;
      $display("FAIL freeze_load: clk/tick/ack=%b%b%b exp 001", clk_out, tick, div_ack);
    end
    checks++;
    for (int i = 0; i < 14; i++) begin
      drive(0, 1, 0, 0);
      if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
        errors++;
        $display("FAIL freeze_resume cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                 i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
      end
      checks++;
    end
    if (held !== 1'b0 && held !== 1'b1) begin
      errors++;
      $display("FAIL freeze_clk_known: clk_out=%b exp 0 or 1", held);
    end
    checks++;
  endtask

  task automatic test_rst_pending();
    int acks;
    for (int k = 0; k < 16 && m_pos != 1; k++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 7);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    if ({clk_out, tick, div_ack} !== 3'b000) begin
      errors++;
      $display("FAIL rst_pending: clk/tick/ack=%b%b%b exp 000", clk_out, tick, div_ack);
    end
    checks++;
    acks = 0;
    for (int i = 1; i < 17; i++) begin
      drive(0, 1, 0, 0);
      if ({clk_out, tick} !== {((i % 4) >= 2), ((i % 4) == 3)}) begin
        errors++;
        $display("FAIL rst_default cyc %0d: clk/tick=%b%b exp %b%b",
                 i, clk_out, tick, ((i % 4) >= 2), ((i % 4) == 3));
      end
      checks++;
      if (div_ack === 1'b1) acks++;
    end
    if (acks !== 0) begin
      errors++;
      $display("FAIL rst_discard: acks=%0d exp 0", acks);
    end
    checks++;
  endtask

  task automatic test_random();
    bit r, e, l;
    int v;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      v = int'($urandom_range(0, 12));
      drive(r, e, l, v);
      if ({clk_out, tick, div_ack} !== {exp_clk, exp_tick, exp_ack}) begin
        errors++;
        $display("FAIL random cyc %0d: clk/tick/ack=%b%b%b exp %b%b%b",
                 i, clk_out, tick, div_ack, exp_clk, exp_tick, exp_ack);
      end
      checks++;
`ifdef CLK_DIV_PHASE_EN
      if (phase !== W'(exp_pos)) begin
        errors++;
        $display("FAIL random_phase cyc %0d: phase=%0d exp %0d", i, phase, exp_pos);
      end
      checks++;
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_div();
    test_load_mid();
    test_clamp();
    test_multi_load();
    test_freeze();
    test_rst_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
